regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 152 +++++++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: 2 write ports, NUM_RD combinational read ports, per-entry busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.

module regfile_mp_rdport #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]      mem,
  input  logic [2**ADDR_W-1:0]                  busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                                  we0,
  input  logic [ADDR_W-1:0]                     waddr0,
  input  logic [DATA_W-1:0]                     wdata0,
  input  logic                                  we1,
  input  logic [ADDR_W-1:0]                     waddr1,
  input  logic [DATA_W-1:0]                     wdata1,
`endif
  output logic [DATA_W-1:0]                     data,
  output logic                                  busy_o
);

  always_comb begin
    data   = mem[addr];
    busy_o = busy[addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarded data is final, so the entry is no longer pending from the reader's view.
    if (we1 && (waddr1 == addr)) begin
      data   = wdata1;
      busy_o = 1'b0;
    end else if (we0 && (waddr0 == addr)) begin
      data   = wdata0;
      busy_o = 1'b0;
    end
`endif
    if ((ZERO_R0 != 0) && (addr == '0)) begin
      data   = '0;
      busy_o = 1'b0;
    end
    if (rst || !en) begin
      data   = '0;
      busy_o = 1'b0;
    end
  end

endmodule

module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic                       sb_stall,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic sb_acc, inc, dec0, dec1;

  assign sb_stall = !rst && sb_set && busy_q[sb_addr];
  assign sb_acc   = sb_set && !busy_q[sb_addr];
  assign busy_cnt = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (we0) begin
      mem_d[waddr0]  = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (we1) begin
      mem_d[waddr1]  = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    // Reserve is applied last so it wins over a same-cycle write to the same entry.
    if (sb_acc) busy_d[sb_addr] = 1'b1;
    if (ZERO_R0 != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Incremental popcount: an accepted reserve targets a non-busy entry, so it never
  // overlaps a clear; port 1 only counts a clear port 0 did not already count.
  always_comb begin
    inc   = sb_acc && !((ZERO_R0 != 0) && (sb_addr == '0));
    dec0  = we0 && busy_q[waddr0];
    dec1  = we1 && busy_q[waddr1] && !(we0 && (waddr0 == waddr1));
    cnt_d = cnt_q + CW'(inc) - CW'(dec0) - CW'(dec1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) u_rd (
      .rst   (rst),
      .en    (rd_en[k]),
      .addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem   (mem_q),
      .busy  (busy_q),
`ifdef REGFILE_BYPASS_EN
      .we0   (we0),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .we1   (we1),
      .waddr1(waddr1),
      .wdata1(wdata1),
`endif
      .data  (rd_data[k*DATA_W +: DATA_W]),
      .busy_o(rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with hand-computed expectations.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              we0, we1, sb_set;
  logic [AW-1:0]     waddr0, waddr1, sb_addr;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              sb_stall;
  logic [AW:0]       busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_stall(sb_stall), .busy_cnt(busy_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rdat(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; sb_addr = '0;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst = 1; rd_en = '1; rd_addr = '0;
    // Reset state, including a reserve request held during reset
    #12;
    sb_set = 1; sb_addr = 5'd6; #1;
    check("rst_stall", sb_stall, 0);
    check("rst_cnt", busy_cnt, 0);
    check("rst_busy", rd_busy, 0);
    @(negedge clk); idle(); rst = 0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a)); rd(1, 5'(a)); rd(2, 5'(31 - a)); #1;
      check("init_p0", rdat(0), 0);
      check("init_p2", rdat(2), 0);
    end
    check("init_cnt", busy_cnt, 0);

    // Same-address dual write: port 1 wins
    @(negedge clk);
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'h12345678;
    rd(0, 5'd3); #1;
`ifdef REGFILE_BYPASS_EN
    check("dw_same_cyc", rdat(0), 32'h12345678);
`else
    check("dw_same_cyc", rdat(0), 0);
`endif
    edge_settle(); idle();
    check("dw_p1_wins", rdat(0), 32'h12345678);

    // Two different addresses, then independent/duplicate reads and rd_en masking
    @(negedge clk);
    we0 = 1; waddr0 = 5'd1; wdata0 = 32'h11110001;
    we1 = 1; waddr1 = 5'd2; wdata1 = 32'h22220002;
    edge_settle(); idle();
    rd(0, 5'd1); rd(1, 5'd2); rd(2, 5'd1); #1;
    check("rd_p0", rdat(0), 32'h11110001);
    check("rd_p1", rdat(1), 32'h22220002);
    check("rd_dup", rdat(2), 32'h11110001);
    rd_en = 3'b101; #1;
    check("rd_en_off", rdat(1), 0);
    check("rd_en_on", rdat(2), 32'h11110001);
    rd_en = '1;

    // Scoreboard reserve / stall / clear on addr 7
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd7; #1;
    check("sb_first_stall", sb_stall, 0);
    edge_settle(); idle();
    check("sb_cnt1", busy_cnt, 1);
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd7; rd(0, 5'd7); #1;
    check("sb_stall", sb_stall, 1);
    check("sb_rd_busy", rd_busy[0], 1);
    edge_settle(); idle();
    check("sb_stall_nochg", busy_cnt, 1);
    @(negedge clk);
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h00000070; #1;
`ifdef REGFILE_BYPASS_EN
    check("sb_wr_busy_cyc", rd_busy[0], 0);
`else
    check("sb_wr_busy_cyc", rd_busy[0], 1);
`endif
    edge_settle(); idle();
    check("sb_clr_cnt", busy_cnt, 0);
    check("sb_clr_busy", rd_busy[0], 0);
    check("sb_clr_data", rdat(0), 32'h00000070);

    // Forwarding behaviour on a reserved entry 9
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd9;
    edge_settle(); idle();
    @(negedge clk);
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'hDEADBEEF; rd(1, 5'd9); #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", rdat(1), 32'hDEADBEEF);
    check("byp_busy", rd_busy[1], 0);
`else
    check("byp_data", rdat(1), 0);
    check("byp_busy", rd_busy[1], 1);
`endif
    edge_settle(); idle();
    check("byp_next", rdat(1), 32'hDEADBEEF);
    check("byp_next_busy", rd_busy[1], 0);
    check("byp_cnt", busy_cnt, 0);

    // Double clear in one cycle: count drops by 2
    @(negedge clk); sb_set = 1; sb_addr = 5'd10;
    edge_settle();
    @(negedge clk); sb_set = 1; sb_addr = 5'd11;
    edge_settle(); idle();
    check("dbl_cnt2", busy_cnt, 2);
    @(negedge clk);
    we0 = 1; waddr0 = 5'd10; wdata0 = 32'hA;
    we1 = 1; waddr1 = 5'd11; wdata1 = 32'hB;
    edge_settle(); idle();
    check("dbl_cnt0", busy_cnt, 0);

    // Reserve and write to the same non-busy entry: reserve wins
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd12; we0 = 1; waddr0 = 5'd12; wdata0 = 32'h5;
    edge_settle(); idle();
    rd(2, 5'd12); #1;
    check("rw_busy", rd_busy[2], 1);
    check("rw_cnt", busy_cnt, 1);
    check("rw_data", rdat(2), 32'h5);
    @(negedge clk); we1 = 1; waddr1 = 5'd12; wdata1 = 32'h6;
    edge_settle(); idle();
    check("rw_clr_cnt", busy_cnt, 0);

    // Entry 0 is hardwired to zero and never busy
    @(negedge clk);
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    sb_set = 1; sb_addr = 5'd0; rd(0, 5'd0); #1;
    check("r0_stall", sb_stall, 0);
    check("r0_same_cyc", rdat(0), 0);
    edge_settle(); idle();
    check("r0_data", rdat(0), 0);
    check("r0_busy", rd_busy[0], 0);
    check("r0_cnt", busy_cnt, 0);

    // Mid-cycle reset discards a pending write and all reservations
    @(negedge clk); sb_set = 1; sb_addr = 5'd4;
    edge_settle();
    @(negedge clk); sb_set = 1; sb_addr = 5'd5;
    edge_settle(); idle();
    check("mr_cnt2", busy_cnt, 2);
    @(negedge clk);
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'h77; rd(0, 5'd4); rd(1, 5'd3);
    #2 rst = 1; #1;
    check("mr_cnt_async", busy_cnt, 0);
    check("mr_rd0_async", rdat(0), 0);
    check("mr_busy_async", rd_busy, 0);
    @(posedge clk);
    @(negedge clk); rst = 0; idle(); #1;
    check("mr_e4", rdat(0), 0);
    check("mr_e3", rdat(1), 0);
    check("mr_cnt", busy_cnt, 0);
    check("mr_busy", rd_busy, 0);

    // First edge after reset behaves normally
    @(negedge clk); we0 = 1; waddr0 = 5'd4; wdata0 = 32'h1;
    edge_settle(); idle();
    check("post_rst_wr", rdat(0), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
